// File: rtl/bus_initiator.sv
// Purpose: turns one host request into an address cycle plus a four-beat burst on the shared AddrData bus.
// Latency: ADDR the cycle after acceptance; done 6 cycles (write) or 6+RD_LAT cycles (read) after acceptance.
// Backpressure: req_ready only in IDLE; a req_valid held while busy is taken in the first IDLE cycle.
module bus_initiator #(
    parameter int RD_LAT = 1
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_rw,
    input  logic [15:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        done,
    output logic [63:0] rsp_rdata,
    output logic        busy,
    output logic        AddrValid,
    output logic        rw,
    inout  logic [15:0] AddrData
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ADDR  = 3'd1,
        WDATA = 3'd2,
        RWAIT = 3'd3,
        RDATA = 3'd4,
        TURN  = 3'd5
    } state_t;

    // Last value of the latency counter before the first read beat (unused when RD_LAT is 0).
    localparam logic [1:0] LAT_LAST = 2'(RD_LAT - 1);

    state_t      state;
    state_t      state_nxt;
    logic [1:0]  beat_cnt;
    logic [1:0]  lat_cnt;
    logic        rw_q;
    logic [15:0] addr_q;
    logic [63:0] wdata_q;
    logic [47:0] cap_q;
    logic        drv_en;
    logic [15:0] drv_dat;

    // The bus is only ever driven from state, so an async reset releases it at once.
    assign AddrData = drv_en ? drv_dat : 16'hzzzz;

    // State register.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and all bus/host outputs decoded from the current state.
    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        AddrValid = 1'b0;
        rw        = 1'b1;
        drv_en    = 1'b0;
        drv_dat   = 16'h0000;
        case (state)
            IDLE: begin
                busy      = 1'b0;
                req_ready = 1'b1;
                if (req_valid) begin
                    state_nxt = ADDR;
                end
            end
            ADDR: begin
                AddrValid = 1'b1;
                rw        = rw_q;
                drv_en    = 1'b1;
                drv_dat   = addr_q;
                if (!rw_q) begin
                    state_nxt = WDATA;
                end else if (RD_LAT == 0) begin
                    state_nxt = RDATA;
                end else begin
                    state_nxt = RWAIT;
                end
            end
            WDATA: begin
                rw      = rw_q;
                drv_en  = 1'b1;
                drv_dat = wdata_q[{beat_cnt, 4'b0000} +: 16];
                if (beat_cnt == 2'd3) begin
                    state_nxt = TURN;
                end
            end
            RWAIT: begin
                rw = rw_q;
                if (lat_cnt == LAT_LAST) begin
                    state_nxt = RDATA;
                end
            end
            RDATA: begin
                rw = rw_q;
                if (beat_cnt == 2'd3) begin
                    state_nxt = TURN;
                end
            end
            TURN: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Register the request at acceptance; host inputs are ignored afterwards.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            rw_q    <= 1'b1;
            addr_q  <= 16'h0000;
            wdata_q <= 64'h0;
        end else if (state == IDLE && req_valid) begin
            rw_q    <= req_rw;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
        end
    end

    // Beat counter runs through WDATA/RDATA, latency counter through RWAIT; both sit at 0 elsewhere.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            beat_cnt <= 2'd0;
            lat_cnt  <= 2'd0;
        end else begin
            beat_cnt <= (state == WDATA || state == RDATA) ? beat_cnt + 2'd1 : 2'd0;
            lat_cnt  <= (state == RWAIT) ? lat_cnt + 2'd1 : 2'd0;
        end
    end

    // Capture read beats; the last beat publishes the whole burst so rsp_rdata is valid with done.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            cap_q     <= 48'h0;
            rsp_rdata <= 64'h0;
        end else if (state == RDATA) begin
            case (beat_cnt)
                2'd0:    cap_q[15:0]  <= AddrData;
                2'd1:    cap_q[31:16] <= AddrData;
                2'd2:    cap_q[47:32] <= AddrData;
                default: rsp_rdata    <= {AddrData, cap_q};
            endcase
        end
    end

endmodule

// File: tb/tb_bus_initiator.sv
// Purpose: directed bench for bus_initiator at RD_LAT 1 (main), 0 and 3, each with a paged responder on its own bus.
// Latency: a per-instance monitor checks every burst cycle against queued expectations.
// Backpressure: requests are held until each targeted instance accepts; bounded waits throughout.
module tb_bus_initiator;

    typedef struct {
        logic        rd;
        logic        b2b;
        logic [15:0] addr;
        logic [63:0] wdata;
        logic [63:0] rdata;
    } exp_t;

    logic        clk       = 1'b0;
    logic        resetN    = 1'b0;
    logic [2:0]  req_valid = 3'b000;
    logic        req_rw    = 1'b0;
    logic [15:0] req_addr  = 16'h0000;
    logic [63:0] req_wdata = 64'h0;
    logic [2:0]  req_ready;
    logic [2:0]  done;
    logic [2:0]  busy;
    logic [2:0]  addr_valid;
    logic [2:0]  rw_o;
    int          checks    = 0;
    int          failures  = 0;
    int          cyc       = 0;
    int          acc_cyc [3];

    // Free-running clock and cycle counter.
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : inst
        localparam int LAT = (g == 0) ? 1 : ((g == 1) ? 0 : 3);
        tri1 [15:0]  bus;
        logic [15:0] mem [256];
        logic [15:0] base = 16'h0000;
        logic        rd   = 1'b0;
        int          k    = 0;
        logic        drv;
        logic [15:0] drv_dat;
        logic [63:0] rdata;
        exp_t        q[$];
        exp_t        cur;
        logic        active    = 1'b0;
        int          acyc      = 0;
        int          last_beat = -100;
        int          d;
        int          lat;
        logic [15:0] eb;
        string       p;

        bus_initiator #(.RD_LAT(LAT)) dut (
            .clk       (clk),
            .resetN    (resetN),
            .req_valid (req_valid[g]),
            .req_ready (req_ready[g]),
            .req_rw    (req_rw),
            .req_addr  (req_addr),
            .req_wdata (req_wdata),
            .done      (done[g]),
            .rsp_rdata (rdata),
            .busy      (busy[g]),
            .AddrValid (addr_valid[g]),
            .rw        (rw_o[g]),
            .AddrData  (bus)
        );

        // Responder: page 2 only, offset wraps within 8 bits, read beats start LAT cycles after ADDR.
        assign drv     = rd && (base[15:12] == 4'h2) && (k >= LAT + 1) && (k <= LAT + 4);
        assign drv_dat = mem[8'(int'(base[7:0]) + k - 1 - LAT)];
        assign bus     = drv ? drv_dat : 16'hzzzz;

        always @(posedge clk or negedge resetN) begin
            if (!resetN) begin
                k <= 0;
            end else if (addr_valid[g]) begin
                base <= bus;
                rd   <= rw_o[g];
                k    <= 1;
            end else if (k > 0) begin
                if (!rd && k <= 4 && base[15:12] == 4'h2) begin
                    mem[8'(int'(base[7:0]) + k - 1)] <= bus;
                end
                k <= (k >= 8) ? 0 : k + 1;
            end
        end

        // Monitor: pops an expectation at each address cycle and checks every cycle of the burst.
        initial begin
            p = $sformatf("i%0d_", g);
            forever begin
                @(negedge clk);
                if (!resetN) begin
                    active = 1'b0;
                    q.delete();
                end else if (addr_valid[g]) begin
                    check({p, "addr_expected"}, 64'(q.size() != 0), 64'd1);
                    if (q.size() != 0) begin
                        cur = q.pop_front();
                        check({p, "addr_value"}, 64'(bus), 64'(cur.addr));
                        check({p, "addr_rw"}, 64'(rw_o[g]), 64'(cur.rd));
                        check({p, "addr_latency"}, 64'(cyc), 64'(acc_cyc[g] + 1));
                        // Two idle bus cycles (TURN, IDLE) between the last beat and the next address.
                        if (cur.b2b) check({p, "b2b_gap"}, 64'(cyc - last_beat), 64'd3);
                        active = 1'b1;
                        acyc   = cyc;
                    end
                end else if (active) begin
                    d   = cyc - acyc;
                    lat = cur.rd ? LAT : 0;
                    check({p, "busy"}, 64'(busy[g]), 64'd1);
                    check({p, "ready"}, 64'(req_ready[g]), 64'd0);
                    check({p, "done"}, 64'(done[g]), 64'(d == lat + 5));
                    check({p, "rw"}, 64'(rw_o[g]), (d == lat + 5) ? 64'd1 : 64'(cur.rd));
                    if (!cur.rd && d <= 4) eb = cur.wdata[16 * (d - 1) +: 16];
                    else if (cur.rd && d > lat && d <= lat + 4) eb = cur.rdata[16 * (d - lat - 1) +: 16];
                    else eb = 16'hFFFF;
                    check({p, "bus"}, 64'(bus), 64'(eb));
                    if (d == lat + 4) last_beat = cyc;
                    if (d >= lat + 5) begin
                        if (cur.rd) check({p, "rdata"}, rdata, cur.rdata);
                        active = 1'b0;
                    end
                end else begin
                    check({p, "idle_done"}, 64'(done[g]), 64'd0);
                end
            end
        end
    end

    // Queue expectations, then hold req_valid per instance until each one accepts.
    task automatic issue(input logic [2:0] mask, input logic r, input logic b2b,
                         input logic [15:0] a, input logic [63:0] wd, input logic [63:0] er);
        exp_t       e;
        logic [2:0] pend;
        logic [2:0] acc;
        e.rd = r; e.b2b = b2b; e.addr = a; e.wdata = wd; e.rdata = er;
        if (mask[0]) inst[0].q.push_back(e);
        if (mask[1]) inst[1].q.push_back(e);
        if (mask[2]) inst[2].q.push_back(e);
        req_rw    = r;
        req_addr  = a;
        req_wdata = wd;
        pend      = mask;
        req_valid = pend;
        for (int t = 0; t < 64 && pend != 3'b000; t++) begin
            acc = pend & req_ready;
            for (int i = 0; i < 3; i++) if (acc[i]) acc_cyc[i] = cyc;
            @(posedge clk);
            pend = pend & ~acc;
            @(negedge clk);
            req_valid = pend;
        end
        check("accept_timeout", 64'(pend), 64'd0);
    endtask

    task automatic wait_idle();
        int t = 0;
        while (t < 100 && (busy != 3'b000 || inst[0].active || inst[1].active || inst[2].active)) begin
            @(negedge clk);
            t++;
        end
        check("idle_timeout", 64'(t < 100), 64'd1);
        @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_addr_valid", 64'(addr_valid), 64'd0);
        check("rst_rw", 64'(rw_o), 64'h7);
        check("rst_done", 64'(done), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_rdata", inst[0].rdata, 64'h0);
        check("rst_bus0", 64'(inst[0].bus), 64'hFFFF);
        check("rst_bus2", 64'(inst[2].bus), 64'hFFFF);
        resetN = 1'b1;
        @(negedge clk);
        check("rst_ready", 64'(req_ready), 64'h7);

        // Write then read page 2 on all three latencies.
        issue(3'b111, 1'b0, 1'b0, 16'h2010, 64'hA003_A002_A001_A000, 64'h0);
        wait_idle();
        check("mem_i0_2010", {inst[0].mem[8'h13], inst[0].mem[8'h12], inst[0].mem[8'h11], inst[0].mem[8'h10]}, 64'hA003_A002_A001_A000);
        check("mem_i1_2010", {inst[1].mem[8'h13], inst[1].mem[8'h12], inst[1].mem[8'h11], inst[1].mem[8'h10]}, 64'hA003_A002_A001_A000);
        check("mem_i2_2010", {inst[2].mem[8'h13], inst[2].mem[8'h12], inst[2].mem[8'h11], inst[2].mem[8'h10]}, 64'hA003_A002_A001_A000);
        issue(3'b111, 1'b1, 1'b0, 16'h2010, 64'h0, 64'hA003_A002_A001_A000);
        wait_idle();

        // Back-to-back write then read with req_valid held high throughout.
        issue(3'b001, 1'b0, 1'b0, 16'h2020, 64'hB003_B002_B001_B000, 64'h0);
        issue(3'b001, 1'b1, 1'b1, 16'h2020, 64'h0, 64'hB003_B002_B001_B000);
        wait_idle();

        // Offset wrap is the responder's job; the initiator only sends the base.
        issue(3'b001, 1'b0, 1'b0, 16'h20FE, 64'hC003_C002_C001_C000, 64'h0);
        wait_idle();
        check("mem_wrap", {inst[0].mem[8'h01], inst[0].mem[8'h00], inst[0].mem[8'hFF], inst[0].mem[8'hFE]}, 64'hC003_C002_C001_C000);
        check("rdata_held", inst[0].rdata, 64'hB003_B002_B001_B000);

        // Reset during WDATA beat 2: bus released asynchronously, burst abandoned.
        issue(3'b001, 1'b0, 1'b0, 16'h2030, 64'hD003_D002_D001_D000, 64'h0);
        repeat (3) @(posedge clk);
        #2 resetN = 1'b0;
        #1;
        check("mid_rst_bus", 64'(inst[0].bus), 64'hFFFF);
        check("mid_rst_addr_valid", 64'(addr_valid[0]), 64'd0);
        check("mid_rst_rw", 64'(rw_o[0]), 64'd1);
        check("mid_rst_busy", 64'(busy[0]), 64'd0);
        check("mid_rst_done", 64'(done[0]), 64'd0);
        check("mid_rst_rdata", inst[0].rdata, 64'h0);
        @(negedge clk);
        check("mid_rst_done2", 64'(done[0]), 64'd0);
        resetN = 1'b1;
        @(negedge clk);
        check("post_rst_ready", 64'(req_ready[0]), 64'd1);
        issue(3'b001, 1'b0, 1'b0, 16'h2040, 64'hE003_E002_E001_E000, 64'h0);
        wait_idle();
        issue(3'b001, 1'b1, 1'b0, 16'h2040, 64'h0, 64'hE003_E002_E001_E000);
        wait_idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Overall time bound in case a wait never resolves.
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
